// File: rtl/hdmi_timing_pkg.sv
// Shared period codes, control-symbol constants and island/preamble lengths
// for the HDMI timing generator and its island sequencer.
package hdmi_timing_pkg;

  typedef enum logic [2:0] {
    P_CONTROL         = 3'd0,
    P_VID_PRE         = 3'd1,
    P_VID_GUARD       = 3'd2,
    P_VID_ACTIVE      = 3'd3,
    P_ISL_PRE         = 3'd4,
    P_ISL_GUARD_LEAD  = 3'd5,
    P_ISL_DATA        = 3'd6,
    P_ISL_GUARD_TRAIL = 3'd7
  } period_e;

  localparam logic [3:0] CTL_NONE   = 4'b0000;
  localparam logic [3:0] CTL_VIDEO  = 4'b0001;
  localparam logic [3:0] CTL_ISLAND = 4'b0101;

  localparam int PREAMBLE_LEN  = 8;
  localparam int GUARD_LEN     = 2;
  localparam int PACKET_LEN    = 32;
  // Minimum control pixels that must surround an island within a line.
  localparam int ISLAND_MARGIN = 12;

  function automatic logic [3:0] ctl_for(input period_e p);
    case (p)
      P_VID_PRE: ctl_for = CTL_VIDEO;
      P_ISL_PRE: ctl_for = CTL_ISLAND;
      default:   ctl_for = CTL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_island_seq.sv
// Data-island sequencer: after a start strobe walks preamble, leading guard,
// packet data and trailing guard, presenting the period code and pixel index.
module hdmi_island_seq
  import hdmi_timing_pkg::*;
#(
  parameter int ISLAND_PACKETS = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  output period_e period,
  output logic [5:0] index
);

  localparam int DATA_LEN = PACKET_LEN * ISLAND_PACKETS;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRE         = 3'd1,
    S_GUARD_LEAD  = 3'd2,
    S_DATA        = 3'd3,
    S_GUARD_TRAIL = 3'd4
  } state_e;

  state_e     state_r;
  logic [6:0] cnt_r;
  period_e    period_r;
  logic [5:0] index_r;

  // Island state machine; period and index are registered with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= S_IDLE;
      cnt_r    <= 7'd0;
      period_r <= P_CONTROL;
      index_r  <= 6'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r   <= 7'd0;
          index_r <= 6'd0;
          if (start) begin
            state_r  <= S_PRE;
            period_r <= P_ISL_PRE;
          end else begin
            state_r  <= S_IDLE;
            period_r <= P_CONTROL;
          end
        end
        S_PRE: begin
          if (cnt_r == 7'(PREAMBLE_LEN - 1)) begin
            state_r  <= S_GUARD_LEAD;
            period_r <= P_ISL_GUARD_LEAD;
            cnt_r    <= 7'd0;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        S_GUARD_LEAD: begin
          if (cnt_r == 7'(GUARD_LEN - 1)) begin
            state_r  <= S_DATA;
            period_r <= P_ISL_DATA;
            cnt_r    <= 7'd0;
            index_r  <= 6'd0;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        S_DATA: begin
          if (cnt_r == 7'(DATA_LEN - 1)) begin
            state_r  <= S_GUARD_TRAIL;
            period_r <= P_ISL_GUARD_TRAIL;
            cnt_r    <= 7'd0;
            index_r  <= 6'd0;
          end else begin
            cnt_r   <= cnt_r + 7'd1;
            index_r <= 6'(cnt_r + 7'd1);
          end
        end
        S_GUARD_TRAIL: begin
          if (cnt_r == 7'(GUARD_LEN - 1)) begin
            state_r  <= S_IDLE;
            period_r <= P_CONTROL;
            cnt_r    <= 7'd0;
          end else begin
            cnt_r <= cnt_r + 7'd1;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          period_r <= P_CONTROL;
          cnt_r    <= 7'd0;
          index_r  <= 6'd0;
        end
      endcase
    end
  end

  assign period = period_r;
  assign index  = index_r;

endmodule

// File: rtl/hdmi_timing.sv
// Parametrised HDMI/DVI timing generator: beam position, blanking, syncs and
// HDMI period sequencing including requested data islands.
module hdmi_timing
  import hdmi_timing_pkg::*;
#(
  parameter int H_IMAGE        = 720,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 62,
  parameter int H_BACK         = 60,
  parameter int V_IMAGE        = 480,
  parameter int V_FRONT        = 9,
  parameter int V_SYNC         = 6,
  parameter int V_BACK         = 30,
  parameter int H_INVERT       = 1,
  parameter int V_INVERT       = 1,
  parameter int HDMI_MODE      = 1,
  parameter int ISLAND_OFFSET  = 12,
  parameter int ISLAND_PACKETS = 1,
  parameter int POS_BITS       = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                island_req,
  output logic [POS_BITS-1:0] hpos,
  output logic [POS_BITS-1:0] vpos,
  output logic                in_hblank,
  output logic                in_vblank,
  output logic                in_image,
  output logic                hsync,
  output logic                vsync,
  output logic [2:0]          period,
  output logic [3:0]          ctl,
  output logic                island_ack,
  output logic [5:0]          island_index,
  output logic                frame_start
);

  localparam int WIDTH  = H_IMAGE + H_FRONT + H_SYNC + H_BACK;
  localparam int HEIGHT = V_IMAGE + V_FRONT + V_SYNC + V_BACK;
  localparam int VID_LEAD = PREAMBLE_LEN + GUARD_LEN;

  localparam logic [POS_BITS-1:0] POS_ZERO  = POS_BITS'(0);
  localparam logic [POS_BITS-1:0] POS_ONE   = POS_BITS'(1);
  localparam logic [POS_BITS-1:0] H_IMG     = POS_BITS'(H_IMAGE);
  localparam logic [POS_BITS-1:0] H_RST_CNT = POS_BITS'(H_IMAGE + 1);
  localparam logic [POS_BITS-1:0] H_LAST    = POS_BITS'(WIDTH - 1);
  localparam logic [POS_BITS-1:0] HS_START  = POS_BITS'(H_IMAGE + H_FRONT);
  localparam logic [POS_BITS-1:0] HS_END    = POS_BITS'(H_IMAGE + H_FRONT + H_SYNC);
  localparam logic [POS_BITS-1:0] VPRE_AT   = POS_BITS'(WIDTH - VID_LEAD);
  localparam logic [POS_BITS-1:0] VGRD_AT   = POS_BITS'(WIDTH - GUARD_LEN);
  localparam logic [POS_BITS-1:0] ISL_AT    = POS_BITS'(H_IMAGE + ISLAND_OFFSET - 1);
  localparam logic [POS_BITS-1:0] V_IMG     = POS_BITS'(V_IMAGE);
  localparam logic [POS_BITS-1:0] V_IMG_M1  = POS_BITS'(V_IMAGE - 1);
  localparam logic [POS_BITS-1:0] V_LAST    = POS_BITS'(HEIGHT - 1);
  localparam logic [POS_BITS-1:0] VS_START  = POS_BITS'(V_IMAGE + V_FRONT);
  localparam logic [POS_BITS-1:0] VS_END    = POS_BITS'(V_IMAGE + V_FRONT + V_SYNC);
  localparam bit H_INV   = (H_INVERT != 0);
  localparam bit V_INV   = (V_INVERT != 0);
  localparam bit HDMI_EN = (HDMI_MODE != 0);

  if (H_IMAGE + ISLAND_OFFSET + ISLAND_MARGIN + PACKET_LEN * ISLAND_PACKETS
      + ISLAND_MARGIN > WIDTH - VID_LEAD) begin : g_chk_fit
    $error("hdmi_timing: island does not leave 12 control pixels before video preamble");
  end
  if (ISLAND_OFFSET < 4) begin : g_chk_offset
    $error("hdmi_timing: ISLAND_OFFSET must be at least 4");
  end
  if (ISLAND_PACKETS < 1 || ISLAND_PACKETS > 2) begin : g_chk_packets
    $error("hdmi_timing: ISLAND_PACKETS must be 1 or 2");
  end
  if (WIDTH > (1 << POS_BITS) || HEIGHT > (1 << POS_BITS)) begin : g_chk_bits
    $error("hdmi_timing: POS_BITS too narrow for the frame");
  end

  // h_cnt_r/v_cnt_r run one pixel ahead of hpos/vpos so every output is a
  // registered decode of the position it is presented with.
  logic [POS_BITS-1:0] h_cnt_r, v_cnt_r, h_next_s, v_next_s;
  logic                h_last_s, v_last_s;
  logic                hblank_s, vblank_s, image_s, hs_act_s, vs_act_s, next_active_s;
  logic                isl_start_s;
  period_e             vid_period_s, period_s, isl_period_s;
  logic [5:0]          isl_index_s;

  logic [POS_BITS-1:0] hpos_r, vpos_r;
  logic                hblank_r, vblank_r, image_r, hsync_r, vsync_r;
  period_e             period_r;
  logic [3:0]          ctl_r;
  logic                ack_r, frame_start_r;
  logic [5:0]          index_r;

  hdmi_island_seq #(
    .ISLAND_PACKETS(ISLAND_PACKETS)
  ) u_island_seq (
    .clk   (clk),
    .reset (reset),
    .start (isl_start_s),
    .period(isl_period_s),
    .index (isl_index_s)
  );

  // Position counter advance with horizontal and vertical wrap.
  always_comb begin
    h_last_s = (h_cnt_r == H_LAST);
    v_last_s = (v_cnt_r == V_LAST);
    if (h_last_s) begin
      h_next_s = POS_ZERO;
      if (v_last_s) begin
        v_next_s = POS_ZERO;
      end else begin
        v_next_s = v_cnt_r + POS_ONE;
      end
    end else begin
      h_next_s = h_cnt_r + POS_ONE;
      v_next_s = v_cnt_r;
    end
  end

  // Blanking, sync and period decode of the leading position.
  always_comb begin
    hblank_s      = (h_cnt_r >= H_IMG);
    vblank_s      = (v_cnt_r >= V_IMG);
    image_s       = !hblank_s && !vblank_s;
    hs_act_s      = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
    vs_act_s      = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
    next_active_s = (v_cnt_r == V_LAST) || (v_cnt_r < V_IMG_M1);
    isl_start_s   = HDMI_EN && island_req && (h_cnt_r == ISL_AT);
    if (image_s) begin
      vid_period_s = P_VID_ACTIVE;
    end else if (HDMI_EN && next_active_s && (h_cnt_r >= VGRD_AT)) begin
      vid_period_s = P_VID_GUARD;
    end else if (HDMI_EN && next_active_s && (h_cnt_r >= VPRE_AT)) begin
      vid_period_s = P_VID_PRE;
    end else begin
      vid_period_s = P_CONTROL;
    end
    // Islands end well before the video preamble, so the two never overlap.
    if (isl_period_s != P_CONTROL) begin
      period_s = isl_period_s;
    end else begin
      period_s = vid_period_s;
    end
  end

  // Position counters and the registered output stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_cnt_r       <= H_RST_CNT;
      v_cnt_r       <= V_LAST;
      hpos_r        <= H_IMG;
      vpos_r        <= V_LAST;
      hblank_r      <= 1'b1;
      vblank_r      <= 1'b1;
      image_r       <= 1'b0;
      hsync_r       <= H_INV;
      vsync_r       <= V_INV;
      period_r      <= P_CONTROL;
      ctl_r         <= CTL_NONE;
      ack_r         <= 1'b0;
      index_r       <= 6'd0;
      frame_start_r <= 1'b0;
    end else begin
      h_cnt_r       <= h_next_s;
      v_cnt_r       <= v_next_s;
      hpos_r        <= h_cnt_r;
      vpos_r        <= v_cnt_r;
      hblank_r      <= hblank_s;
      vblank_r      <= vblank_s;
      image_r       <= image_s;
      hsync_r       <= hs_act_s ^ H_INV;
      vsync_r       <= vs_act_s ^ V_INV;
      period_r      <= period_s;
      ctl_r         <= ctl_for(period_s);
      ack_r         <= isl_start_s;
      index_r       <= isl_index_s;
      frame_start_r <= (h_cnt_r == POS_ZERO) && (v_cnt_r == POS_ZERO);
    end
  end

  assign hpos         = hpos_r;
  assign vpos         = vpos_r;
  assign in_hblank    = hblank_r;
  assign in_vblank    = vblank_r;
  assign in_image     = image_r;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign period       = period_r;
  assign ctl          = ctl_r;
  assign island_ack   = ack_r;
  assign island_index = index_r;
  assign frame_start  = frame_start_r;

endmodule

// File: tb/tb_hdmi_timing.sv
// Directed bench: default timing, a short-frame two-packet HDMI instance and
// a small DVI instance, each checked against hand-derived beam/period values.
`timescale 1ns/1ps
module tb_hdmi_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic rst_def, rst_pk, rst_dvi;
  logic req_def, req_pk, req_dvi;

  logic [9:0] d_hpos, d_vpos, p_hpos, p_vpos, x_hpos, x_vpos;
  logic d_hb, d_vb, d_img, d_hs, d_vs, d_ack, d_fs;
  logic p_hb, p_vb, p_img, p_hs, p_vs, p_ack, p_fs;
  logic x_hb, x_vb, x_img, x_hs, x_vs, x_ack, x_fs;
  logic [2:0] d_per, p_per, x_per;
  logic [3:0] d_ctl, p_ctl, x_ctl;
  logic [5:0] d_idx, p_idx, x_idx;

  hdmi_timing u_def (
    .clk(clk), .reset(rst_def), .island_req(req_def),
    .hpos(d_hpos), .vpos(d_vpos), .in_hblank(d_hb), .in_vblank(d_vb),
    .in_image(d_img), .hsync(d_hs), .vsync(d_vs), .period(d_per), .ctl(d_ctl),
    .island_ack(d_ack), .island_index(d_idx), .frame_start(d_fs)
  );

  // Default horizontal timing, 10-line frame (image 0..3, vsync 6..7), two packets.
  hdmi_timing #(
    .V_IMAGE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .ISLAND_PACKETS(2)
  ) u_pk (
    .clk(clk), .reset(rst_pk), .island_req(req_pk),
    .hpos(p_hpos), .vpos(p_vpos), .in_hblank(p_hb), .in_vblank(p_vb),
    .in_image(p_img), .hsync(p_hs), .vsync(p_vs), .period(p_per), .ctl(p_ctl),
    .island_ack(p_ack), .island_index(p_idx), .frame_start(p_fs)
  );

  // 172x12 DVI frame: hsync 68..71, vsync line 9.
  hdmi_timing #(
    .H_IMAGE(64), .H_FRONT(4), .H_SYNC(4), .H_BACK(100),
    .V_IMAGE(8), .V_FRONT(1), .V_SYNC(1), .V_BACK(2), .HDMI_MODE(0)
  ) u_dvi (
    .clk(clk), .reset(rst_dvi), .island_req(req_dvi),
    .hpos(x_hpos), .vpos(x_vpos), .in_hblank(x_hb), .in_vblank(x_vb),
    .in_image(x_img), .hsync(x_hs), .vsync(x_vs), .period(x_per), .ctl(x_ctl),
    .island_ack(x_ack), .island_index(x_idx), .frame_start(x_fs)
  );

  task automatic test_reset();
    rst_def = 1'b0; rst_pk = 1'b0; rst_dvi = 1'b0;
    req_def = 1'b0; req_pk = 1'b0; req_dvi = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({d_hpos, d_vpos} !== {10'd720, 10'd524}) begin
      failures++; $display("FAIL reset_pos_def got %0d,%0d want 720,524", d_hpos, d_vpos);
    end
    checks++;
    if ({d_hb, d_vb, d_img, d_hs, d_vs, d_fs} !== 6'b110110) begin
      failures++; $display("FAIL reset_flags_def got %b want 110110", {d_hb, d_vb, d_img, d_hs, d_vs, d_fs});
    end
    checks++;
    if ({d_per, d_ctl, d_ack, d_idx} !== {3'd0, 4'd0, 1'b0, 6'd0}) begin
      failures++; $display("FAIL reset_period_def got per=%0d ctl=%b ack=%b idx=%0d want 0", d_per, d_ctl, d_ack, d_idx);
    end
    checks++;
    if ({p_hpos, p_vpos} !== {10'd720, 10'd9}) begin
      failures++; $display("FAIL reset_pos_pk got %0d,%0d want 720,9", p_hpos, p_vpos);
    end
    checks++;
    if ({x_hpos, x_vpos, x_ack} !== {10'd64, 10'd11, 1'b0}) begin
      failures++; $display("FAIL reset_pos_dvi got %0d,%0d ack=%b want 64,11,0", x_hpos, x_vpos, x_ack);
    end
    rst_def = 1'b1; rst_pk = 1'b1; rst_dvi = 1'b1;
  endtask

  task automatic test_frame_start();
    repeat (137) @(negedge clk);
    checks++;
    if ({d_hpos, d_vpos, d_fs} !== {10'd857, 10'd524, 1'b0}) begin
      failures++; $display("FAIL pre_wrap got %0d,%0d fs=%b want 857,524,0", d_hpos, d_vpos, d_fs);
    end
    @(negedge clk);
    checks++;
    if ({d_hpos, d_vpos, d_fs, d_hb, d_vb, d_img, d_per} !== {10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3}) begin
      failures++; $display("FAIL frame_start got %0d,%0d fs=%b hb=%b vb=%b img=%b per=%0d want 0,0 fs=1 img=1 per=3",
                           d_hpos, d_vpos, d_fs, d_hb, d_vb, d_img, d_per);
    end
    @(negedge clk);
    checks++;
    if ({d_hpos, d_fs} !== {10'd1, 1'b0}) begin
      failures++; $display("FAIL frame_start_pulse got hpos=%0d fs=%b want 1,0", d_hpos, d_fs);
    end
  endtask

  // Default instance lines 0..2: island on line 0, req dropped just before the
  // sample point on line 1, req raised exactly at it on line 2.
  task automatic test_island();
    logic [9:0] eh, ev;
    logic [2:0] ep;
    logic [3:0] ec;
    logic [5:0] ei;
    logic ea, isl;
    int acks;
    eh = 10'd1; ev = 10'd0; acks = 0;
    req_def = 1'b1;
    for (int c = 0; c < 3 * 858 - 1; c++) begin
      isl = (ev == 10'd0) || (ev == 10'd2);
      if (eh < 10'd720) ep = 3'd3;
      else if (isl && eh >= 10'd732 && eh <= 10'd739) ep = 3'd4;
      else if (isl && eh >= 10'd740 && eh <= 10'd741) ep = 3'd5;
      else if (isl && eh >= 10'd742 && eh <= 10'd773) ep = 3'd6;
      else if (isl && eh >= 10'd774 && eh <= 10'd775) ep = 3'd7;
      else if (eh >= 10'd856) ep = 3'd2;
      else if (eh >= 10'd848) ep = 3'd1;
      else ep = 3'd0;
      ec = (ep == 3'd4) ? 4'b0101 : ((ep == 3'd1) ? 4'b0001 : 4'b0000);
      ea = isl && (eh == 10'd731);
      ei = (ep == 3'd6) ? 6'(eh - 10'd742) : 6'd0;
      checks++;
      if ({d_hpos, d_vpos, d_per, d_ctl, d_ack, d_idx} !== {eh, ev, ep, ec, ea, ei}) begin
        failures++;
        $display("FAIL island_def at %0d,%0d got pos=%0d,%0d per=%0d ctl=%b ack=%b idx=%0d want per=%0d ctl=%b ack=%b idx=%0d",
                 eh, ev, d_hpos, d_vpos, d_per, d_ctl, d_ack, d_idx, ep, ec, ea, ei);
      end
      if (d_ack === 1'b1) acks++;
      if (ev == 10'd0 && eh == 10'd800) req_def = 1'b0;
      if (ev == 10'd1 && eh == 10'd100) req_def = 1'b1;
      if (ev == 10'd1 && eh == 10'd730) req_def = 1'b0;
      if (ev == 10'd2 && eh == 10'd730) req_def = 1'b1;
      if (ev == 10'd2 && eh == 10'd800) req_def = 1'b0;
      @(negedge clk);
      if (eh == 10'd857) begin eh = 10'd0; ev = ev + 10'd1; end
      else eh = eh + 10'd1;
    end
    checks++;
    if (acks != 2) begin
      failures++; $display("FAIL island_def_acks got %0d want 2", acks);
    end
  endtask

  task automatic wait_pk(input logic [9:0] h, input logic [9:0] v);
    int n;
    n = 0;
    while (!(p_hpos === h && p_vpos === v) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20000) begin
      failures++; $display("FAIL wait_pk timeout at %0d,%0d want %0d,%0d", p_hpos, p_vpos, h, v);
    end
  endtask

  // Lines 5..9 of the short frame: vsync lines, hsync window, preamble only on line 9.
  task automatic test_vertical();
    logic [9:0] eh, ev;
    logic [2:0] ep;
    logic [3:0] ec;
    logic ehb, evb, eim, ehs, evs;
    wait_pk(10'd0, 10'd5);
    eh = 10'd0; ev = 10'd5;
    for (int c = 0; c < 5 * 858; c++) begin
      ehb = (eh >= 10'd720);
      evb = (ev >= 10'd4);
      eim = !ehb && !evb;
      ehs = !(eh >= 10'd736 && eh <= 10'd797);
      evs = !(ev == 10'd6 || ev == 10'd7);
      if (eim) ep = 3'd3;
      else if (ev == 10'd9 && eh >= 10'd856) ep = 3'd2;
      else if (ev == 10'd9 && eh >= 10'd848) ep = 3'd1;
      else ep = 3'd0;
      ec = (ep == 3'd1) ? 4'b0001 : 4'b0000;
      checks++;
      if ({p_hpos, p_vpos, p_hb, p_vb, p_img, p_hs, p_vs, p_per, p_ctl} !== {eh, ev, ehb, evb, eim, ehs, evs, ep, ec}) begin
        failures++;
        $display("FAIL vertical at %0d,%0d got pos=%0d,%0d flags=%b per=%0d ctl=%b want flags=%b per=%0d ctl=%b",
                 eh, ev, p_hpos, p_vpos, {p_hb, p_vb, p_img, p_hs, p_vs}, p_per, p_ctl,
                 {ehb, evb, eim, ehs, evs}, ep, ec);
      end
      @(negedge clk);
      if (eh == 10'd857) begin eh = 10'd0; ev = (ev == 10'd9) ? 10'd0 : ev + 10'd1; end
      else eh = eh + 10'd1;
    end
    checks++;
    if ({p_hpos, p_vpos, p_fs} !== {10'd0, 10'd0, 1'b1}) begin
      failures++; $display("FAIL vertical_wrap got %0d,%0d fs=%b want 0,0,1", p_hpos, p_vpos, p_fs);
    end
  endtask

  // req held over lines 0..2 of the two-packet instance, dropped before line 3.
  task automatic test_back_to_back();
    logic [9:0] eh, ev;
    logic [2:0] ep;
    logic [3:0] ec;
    logic [5:0] ei;
    logic ea, isl, pre;
    int acks;
    eh = 10'd0; ev = 10'd0; acks = 0;
    req_pk = 1'b1;
    for (int c = 0; c < 4 * 858; c++) begin
      isl = (ev < 10'd3);
      pre = (ev < 10'd3);
      if (eh < 10'd720) ep = 3'd3;
      else if (isl && eh >= 10'd732 && eh <= 10'd739) ep = 3'd4;
      else if (isl && eh >= 10'd740 && eh <= 10'd741) ep = 3'd5;
      else if (isl && eh >= 10'd742 && eh <= 10'd805) ep = 3'd6;
      else if (isl && eh >= 10'd806 && eh <= 10'd807) ep = 3'd7;
      else if (pre && eh >= 10'd856) ep = 3'd2;
      else if (pre && eh >= 10'd848) ep = 3'd1;
      else ep = 3'd0;
      ec = (ep == 3'd4) ? 4'b0101 : ((ep == 3'd1) ? 4'b0001 : 4'b0000);
      ea = isl && (eh == 10'd731);
      ei = (ep == 3'd6) ? 6'(eh - 10'd742) : 6'd0;
      checks++;
      if ({p_hpos, p_vpos, p_per, p_ctl, p_ack, p_idx} !== {eh, ev, ep, ec, ea, ei}) begin
        failures++;
        $display("FAIL back_to_back at %0d,%0d got pos=%0d,%0d per=%0d ctl=%b ack=%b idx=%0d want per=%0d ctl=%b ack=%b idx=%0d",
                 eh, ev, p_hpos, p_vpos, p_per, p_ctl, p_ack, p_idx, ep, ec, ea, ei);
      end
      if (p_ack === 1'b1) acks++;
      if (ev == 10'd2 && eh == 10'd857) req_pk = 1'b0;
      @(negedge clk);
      if (eh == 10'd857) begin eh = 10'd0; ev = ev + 10'd1; end
      else eh = eh + 10'd1;
    end
    checks++;
    if (acks != 3) begin
      failures++; $display("FAIL back_to_back_acks got %0d want 3", acks);
    end
  endtask

  task automatic test_reset_mid_island();
    logic [2:0] ep;
    req_pk = 1'b1;
    wait_pk(10'd750, 10'd4);
    checks++;
    if ({p_per, p_idx} !== {3'd6, 6'd8}) begin
      failures++; $display("FAIL mid_island got per=%0d idx=%0d want 6,8", p_per, p_idx);
    end
    rst_pk = 1'b0; req_pk = 1'b0;
    @(negedge clk);
    checks++;
    if ({p_hpos, p_vpos, p_hb, p_vb, p_img, p_hs, p_vs, p_fs} !== {10'd720, 10'd9, 6'b110110}) begin
      failures++; $display("FAIL reset_abort_pos got %0d,%0d flags=%b want 720,9,110110",
                           p_hpos, p_vpos, {p_hb, p_vb, p_img, p_hs, p_vs, p_fs});
    end
    checks++;
    if ({p_per, p_ctl, p_ack, p_idx} !== {3'd0, 4'd0, 1'b0, 6'd0}) begin
      failures++; $display("FAIL reset_abort_isl got per=%0d ctl=%b ack=%b idx=%0d want 0", p_per, p_ctl, p_ack, p_idx);
    end
    rst_pk = 1'b1; req_pk = 1'b1;
    for (logic [9:0] h = 10'd720; h <= 10'd740; h = h + 10'd1) begin
      if (h >= 10'd740) ep = 3'd5;
      else if (h >= 10'd732) ep = 3'd4;
      else ep = 3'd0;
      checks++;
      if ({p_hpos, p_per, p_ack, p_idx} !== {h, ep, (h == 10'd731), 6'd0}) begin
        failures++; $display("FAIL after_reset at %0d got hpos=%0d per=%0d ack=%b idx=%0d want per=%0d ack=%b idx=0",
                             h, p_hpos, p_per, p_ack, p_idx, ep, (h == 10'd731));
      end
      @(negedge clk);
    end
    req_pk = 1'b0;
  endtask

  task automatic test_dvi();
    logic [9:0] eh, ev;
    logic eim, ehs, evs;
    int n;
    n = 0;
    while (!(x_hpos === 10'd0 && x_vpos === 10'd0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 5000) begin
      failures++; $display("FAIL wait_dvi timeout at %0d,%0d", x_hpos, x_vpos);
    end
    eh = 10'd0; ev = 10'd0;
    for (int c = 0; c < 172 * 12; c++) begin
      eim = (eh < 10'd64) && (ev < 10'd8);
      ehs = !(eh >= 10'd68 && eh <= 10'd71);
      evs = (ev != 10'd9);
      checks++;
      if ({x_hpos, x_vpos, x_img, x_hs, x_vs, x_per, x_ctl, x_ack, x_idx} !==
          {eh, ev, eim, ehs, evs, (eim ? 3'd3 : 3'd0), 4'd0, 1'b0, 6'd0}) begin
        failures++;
        $display("FAIL dvi at %0d,%0d got pos=%0d,%0d img=%b hs=%b vs=%b per=%0d ctl=%b ack=%b want img=%b hs=%b vs=%b",
                 eh, ev, x_hpos, x_vpos, x_img, x_hs, x_vs, x_per, x_ctl, x_ack, eim, ehs, evs);
      end
      @(negedge clk);
      if (eh == 10'd171) begin eh = 10'd0; ev = (ev == 10'd11) ? 10'd0 : ev + 10'd1; end
      else eh = eh + 10'd1;
    end
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_island();
    test_vertical();
    test_back_to_back();
    test_reset_mid_island();
    test_dvi();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
